mantissa_divider: RTL

MANTISSA_DIVIDER -- requirements
Module: mantissa_divider

---
 rtl/div_pkg.sv | 20 ++
 rtl/full_subtractor.sv | 13 +
 rtl/mantissa_divider.sv | 125 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the restoring mantissa divider: default width,
// FSM state encoding and the iteration-count rule.
package div_pkg;

  localparam int DIV_WIDTH = 24;

  // A restoring divider retires exactly one quotient bit per iteration.
  function automatic int iters_for(input int width);
    return width;
  endfunction

  localparam int DIV_ITERS = iters_for(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell used to build the ripple-borrow chain.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic b_out,
  output logic diff
);

  assign diff  = a ^ b ^ b_in;
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/mantissa_divider.sv
// Iterative restoring unsigned divider: one quotient bit per clock, with a
// divide-by-zero fast path that completes on the accepting edge.
module mantissa_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int ITERS = iters_for(WIDTH);
  localparam int CW    = $clog2(ITERS + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(ITERS - 1);

  div_state_e state, state_next;

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_sh;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    iter_cnt;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   sub_b;
  logic [WIDTH:0]   diff;
  logic [WIDTH+1:0] borrow;
  logic             restore;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             accept;
  logic             unused_diff_msb;

  // Subtract chain: trial = {partial remainder, next dividend bit}.
  assign trial     = {rem_q, quo_sh[WIDTH-1]};
  assign sub_b     = {1'b0, dvs_q};
  assign borrow[0] = 1'b0;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
    full_subtractor u_fs (
      .a     (trial[i]),
      .b     (sub_b[i]),
      .b_in  (borrow[i]),
      .b_out (borrow[i+1]),
      .diff  (diff[i])
    );
  end

  // Either branch result is below the divisor, so its top bit is always zero.
  assign restore         = borrow[WIDTH+1];
  assign rem_next        = restore ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_next        = {quo_sh[WIDTH-2:0], ~restore};
  assign unused_diff_msb = diff[WIDTH];

  assign accept = start && (state != RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_next = (divisor == '0) ? DONE : RUN;
        else       state_next = IDLE;
      end
      RUN:     if (iter_cnt == LAST_ITER) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q       <= '0;
      quo_sh      <= '0;
      dvs_q       <= '0;
      iter_cnt    <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      rem_q    <= '0;
      iter_cnt <= '0;
      dvs_q    <= divisor;
      quo_sh   <= dividend;
      // Zero divisor skips iteration and publishes its result immediately.
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      rem_q    <= rem_next;
      quo_sh   <= quo_next;
      iter_cnt <= iter_cnt + 1'b1;
      if (iter_cnt == LAST_ITER) begin
        quotient    <= quo_next;
        remainder   <= rem_next;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
